// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between instruction fetch and the MEM stage,
// one transaction at a time, with byte-lane steering and load extension.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [DATA_WIDTH-1:0] if_data_o,
  output logic                  if_ack_o,
  input  logic [3:0]            mem_op_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic [DATA_WIDTH-1:0] mem_rdata_o,
  output logic                  mem_ack_o,
  output logic                  mem_misalign_o,
  output logic                  stallreq_if_o,
  output logic                  stallreq_mem_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_wdata_o,
  output logic [3:0]            bus_be_o,
  input  logic [DATA_WIDTH-1:0] bus_rdata_i,
  input  logic                  bus_ack_i
);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

  localparam logic [3:0] OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4,
                         OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

  state_t                state, state_nxt;
  logic                  last_d;
  logic                  mis_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  d_pending, is_byte, is_half, is_word, is_store, misalign;
  logic                  grant_i, grant_d;
  logic [3:0]            be_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [DATA_WIDTH-1:0] load_val;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^if_addr_i[1:0];

  assign is_byte   = (mem_op_i == OP_LB) || (mem_op_i == OP_LBU) || (mem_op_i == OP_SB);
  assign is_half   = (mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH);
  assign is_word   = (mem_op_i == OP_LW) || (mem_op_i == OP_SW);
  assign is_store  = (mem_op_i == OP_SB) || (mem_op_i == OP_SH) || (mem_op_i == OP_SW);
  assign d_pending = is_byte || is_half || is_word;
  assign misalign  = (is_half && mem_addr_i[0]) || (is_word && (mem_addr_i[1:0] != 2'b00));

  // Round-robin: on a tie the side that did not win last time gets the bus.
  assign grant_d = (state == IDLE) && d_pending && (!if_req_i || !last_d);
  assign grant_i = (state == IDLE) && if_req_i && !grant_d;

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = mem_data_i;
    if (is_byte) begin
      be_d    = 4'b0001 << mem_addr_i[1:0];
      wdata_d = {4{mem_data_i[7:0]}};
    end else if (is_half) begin
      be_d    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
      wdata_d = {2{mem_data_i[15:0]}};
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d)      state_nxt = misalign ? RESP_D : BUSY_D;
        else if (grant_i) state_nxt = BUSY_I;
      end
      BUSY_I:  if (bus_ack_i) state_nxt = RESP_I;
      BUSY_D:  if (bus_ack_i) state_nxt = RESP_D;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments for all registered state, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      last_d      <= 1'b0;
      mis_q       <= 1'b0;
      rdata_q     <= '0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_be_o    <= 4'b0000;
    end else begin
      state <= state_nxt;
      if (grant_i) begin
        last_d      <= 1'b0;
        mis_q       <= 1'b0;
        bus_req_o   <= 1'b1;
        bus_we_o    <= 1'b0;
        bus_addr_o  <= {if_addr_i[ADDR_WIDTH-1:2], 2'b00};
        bus_be_o    <= 4'b1111;
        bus_wdata_o <= '0;
      end else if (grant_d) begin
        last_d <= 1'b1;
        mis_q  <= misalign;
        if (!misalign) begin
          bus_req_o   <= 1'b1;
          bus_we_o    <= is_store;
          bus_addr_o  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
          bus_be_o    <= be_d;
          bus_wdata_o <= wdata_d;
        end
      end
      if (((state == BUSY_I) || (state == BUSY_D)) && bus_ack_i) begin
        bus_req_o <= 1'b0;
        rdata_q   <= bus_rdata_i;
      end
    end
  end

  // Lane select uses the op/address still held by the stalled MEM stage.
  assign lane_b = rdata_q[{mem_addr_i[1:0], 3'b000} +: 8];
  assign lane_h = rdata_q[{mem_addr_i[1], 4'b0000} +: 16];

  always_comb begin
    load_val = '0;
    case (mem_op_i)
      OP_LB:   load_val = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  load_val = {24'b0, lane_b};
      OP_LH:   load_val = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  load_val = {16'b0, lane_h};
      OP_LW:   load_val = rdata_q;
      default: load_val = '0;
    endcase
  end

  assign if_ack_o       = (state == RESP_I);
  assign if_data_o      = if_ack_o ? rdata_q : '0;
  assign mem_ack_o      = (state == RESP_D) && !mis_q;
  assign mem_misalign_o = (state == RESP_D) && mis_q;
  assign mem_rdata_o    = mem_ack_o ? load_val : '0;
  assign stallreq_mem_o = d_pending && (state != RESP_D);
  assign stallreq_if_o  = if_req_i && (state != RESP_I);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench: transaction-level model compared every cycle, plus
// directed accesses with hand-computed expectations.
module tb_mem_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ack_o;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        mem_misalign_o;
  logic        stallreq_if_o;
  logic        stallreq_mem_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;

  always #5 clk_i = ~clk_i;

  mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
    .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o), .mem_misalign_o(mem_misalign_o),
    .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- spec-level helper functions ----------------
  function automatic bit op_pending(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd8);
  endfunction

  function automatic bit op_store(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

  function automatic bit op_misaligned(input logic [3:0] op, input logic [31:0] a);
    if (op == 4'd2 || op == 4'd5 || op == 4'd7) return a[0];
    if (op == 4'd3 || op == 4'd8) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] op_be(input logic [3:0] op, input logic [31:0] a);
    if (op == 4'd1 || op == 4'd4 || op == 4'd6) return 4'(1 << (a % 4));
    if (op == 4'd2 || op == 4'd5 || op == 4'd7) return ((a % 4) >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] op_wdata(input logic [3:0] op, input logic [31:0] d);
    if (op == 4'd6) return (d & 32'hFF) * 32'h0101_0101;
    if (op == 4'd7) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] op_load(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] w);
    logic [31:0] v;
    v = 32'h0;
    if (op == 4'd1 || op == 4'd4) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (op == 4'd1 && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (op == 4'd2 || op == 4'd5) begin
      v = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
      if (op == 4'd2 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else if (op == 4'd3) begin
      v = w;
    end
    return v;
  endfunction

  // ---------------- bus responder ----------------
  int          lat       = 1;
  logic [31:0] rd_word   = 32'h0;
  logic        stray_ack = 1'b0;
  int          age       = 0;

  always @(posedge clk_i) begin
    #1;
    if (bus_req_o) begin
      age++;
      bus_ack_i   = (age == lat);
      bus_rdata_i = (age == lat) ? rd_word : $urandom;
    end else begin
      age         = 0;
      bus_ack_i   = stray_ack;
      bus_rdata_i = $urandom;
    end
  end

  // ---------------- transaction-level model ----------------
  // phase: 0 = free, 1 = transaction on bus, 2 = response cycle
  int          m_phase  = 0;
  bit          m_side_d = 1'b0;
  bit          m_last_d = 1'b0;
  bit          m_mis    = 1'b0;
  logic [3:0]  m_op     = 4'd0;
  logic [31:0] m_addr   = 32'h0;
  logic [31:0] m_data   = 32'h0;
  logic [31:0] m_word   = 32'h0;
  bit          want_d, want_i;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_phase  = 0;
      m_last_d = 1'b0;
      m_mis    = 1'b0;
    end else if (m_phase == 0) begin
      want_d = op_pending(mem_op_i);
      want_i = if_req_i;
      if (want_d && want_i) begin
        want_d = !m_last_d;
        want_i = m_last_d;
      end
      if (want_d) begin
        m_side_d = 1'b1;
        m_last_d = 1'b1;
        m_op     = mem_op_i;
        m_addr   = mem_addr_i;
        m_data   = mem_data_i;
        m_mis    = op_misaligned(mem_op_i, mem_addr_i);
        m_phase  = m_mis ? 2 : 1;
      end else if (want_i) begin
        m_side_d = 1'b0;
        m_last_d = 1'b0;
        m_op     = 4'd0;
        m_addr   = if_addr_i;
        m_mis    = 1'b0;
        m_phase  = 1;
      end
    end else if (m_phase == 1) begin
      if (bus_ack_i) begin
        m_word  = bus_rdata_i;
        m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
  end

  always @(negedge clk_i) begin
    if (!rst_i) begin
      check("cmp_bus_req", bus_req_o, m_phase == 1);
      if (m_phase == 1) begin
        check("cmp_bus_addr", bus_addr_o, m_addr & 32'hFFFF_FFFC);
        check("cmp_bus_we", bus_we_o, m_side_d && op_store(m_op));
        check("cmp_bus_be", bus_be_o, m_side_d ? op_be(m_op, m_addr) : 4'hF);
        if (m_side_d && op_store(m_op))
          check("cmp_bus_wdata", bus_wdata_o, op_wdata(m_op, m_data));
      end
      check("cmp_if_ack", if_ack_o, m_phase == 2 && !m_side_d);
      check("cmp_mem_ack", mem_ack_o, m_phase == 2 && m_side_d && !m_mis);
      check("cmp_misalign", mem_misalign_o, m_phase == 2 && m_side_d && m_mis);
      check("cmp_stall_if", stallreq_if_o, if_req_i && !(m_phase == 2 && !m_side_d));
      check("cmp_stall_mem", stallreq_mem_o,
            op_pending(mem_op_i) && !(m_phase == 2 && m_side_d));
      if (m_phase == 2 && !m_side_d) check("cmp_if_data", if_data_o, m_word);
      if (m_phase == 2 && m_side_d)
        check("cmp_mem_rdata", mem_rdata_o, m_mis ? 32'h0 : op_load(mem_op_i, mem_addr_i, m_word));
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    int          stalls;
    bit          saw_req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          acked;
    bit          mis;
  } obs_t;

  // Presents one D-side op (DUT idle, called just after a rising edge) and
  // holds it until the access completes, as a stalled MEM stage would.
  task automatic d_access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] rd, input int l, output obs_t o);
    bit done;
    done      = 1'b0;
    o         = '{default: 0};
    lat       = l;
    rd_word   = rd;
    mem_op_i   = op;
    mem_addr_i = addr;
    mem_data_i = data;
    for (int n = 0; n < 30 && !done; n++) begin
      @(negedge clk_i);
      if (stallreq_mem_o) o.stalls++;
      if (bus_req_o && !o.saw_req) begin
        o.saw_req = 1'b1;
        o.addr    = bus_addr_o;
        o.we      = bus_we_o;
        o.be      = bus_be_o;
        o.wdata   = bus_wdata_o;
      end
      if (mem_ack_o || mem_misalign_o) begin
        o.acked = mem_ack_o;
        o.mis   = mem_misalign_o;
        o.rdata = mem_rdata_o;
        done    = 1'b1;
      end
      @(posedge clk_i); #1;
    end
    if (!done) check("d_access_timeout", 32'd0, 32'd1);
    mem_op_i = 4'd0;
  endtask

  obs_t o;
  bit   order[$];
  bit   prev_req, d_done, i_done, i_seen;
  logic [31:0] i_data;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; if_req_i = 1'b0; if_addr_i = 32'h0;
    mem_op_i = 4'd0; mem_addr_i = 32'h0; mem_data_i = 32'h0;
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;

    #12;
    check("rst_bus_req", bus_req_o, 1'b0);
    check("rst_bus_be", bus_be_o, 4'h0);
    check("rst_bus_addr", bus_addr_o, 32'h0);
    check("rst_if_ack", if_ack_o, 1'b0);
    check("rst_mem_ack", mem_ack_o, 1'b0);
    check("rst_misalign", mem_misalign_o, 1'b0);
    check("rst_mem_rdata", mem_rdata_o, 32'h0);
    check("rst_if_data", if_data_o, 32'h0);
    check("rst_stall_mem", stallreq_mem_o, 1'b0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    d_access(4'd3, 32'h100, 32'h0, 32'hDEADBEEF, 2, o);
    check("lw_addr", o.addr, 32'h100);
    check("lw_be", o.be, 4'hF);
    check("lw_we", o.we, 1'b0);
    check("lw_ack", o.acked, 1'b1);
    check("lw_rdata", o.rdata, 32'hDEADBEEF);
    check("lw_stall_cycles", o.stalls, 3);

    d_access(4'd1, 32'h203, 32'h0, 32'h80FFFFFF, 1, o);
    check("lb_be", o.be, 4'b1000);
    check("lb_addr", o.addr, 32'h200);
    check("lb_rdata", o.rdata, 32'hFFFFFF80);
    check("lb_stall_cycles", o.stalls, 2);
    d_access(4'd4, 32'h203, 32'h0, 32'h80FFFFFF, 1, o);
    check("lbu_rdata", o.rdata, 32'h00000080);
    d_access(4'd5, 32'h202, 32'h0, 32'h80FFFFFF, 1, o);
    check("lhu_be", o.be, 4'b1100);
    check("lhu_rdata", o.rdata, 32'h000080FF);
    d_access(4'd2, 32'h200, 32'h0, 32'h12348001, 3, o);
    check("lh_rdata", o.rdata, 32'hFFFF8001);

    d_access(4'd6, 32'h301, 32'h000000A5, 32'h0, 1, o);
    check("sb_we", o.we, 1'b1);
    check("sb_be", o.be, 4'b0010);
    check("sb_wdata", o.wdata, 32'hA5A5A5A5);
    check("sb_ack", o.acked, 1'b1);
    check("sb_rdata", o.rdata, 32'h0);
    d_access(4'd7, 32'h302, 32'h00001234, 32'h0, 1, o);
    check("sh_be", o.be, 4'b1100);
    check("sh_wdata", o.wdata, 32'h12341234);

    d_access(4'd3, 32'h102, 32'h0, 32'h0, 1, o);
    check("mis_lw_no_req", o.saw_req, 1'b0);
    check("mis_lw_flag", o.mis, 1'b1);
    check("mis_lw_ack", o.acked, 1'b0);
    check("mis_lw_stall_cycles", o.stalls, 1);
    d_access(4'd7, 32'h301, 32'h0, 32'h0, 1, o);
    check("mis_sh_flag", o.mis, 1'b1);

    mem_op_i = 4'd9;
    @(negedge clk_i);
    check("op9_no_stall", stallreq_mem_o, 1'b0);
    @(negedge clk_i);
    check("op9_no_req", bus_req_o, 1'b0);
    @(posedge clk_i); #1;
    mem_op_i = 4'd0;

    // Fetch whose request is withdrawn while the bus cycle is in flight.
    lat = 3; rd_word = 32'h00000013;
    if_req_i = 1'b1; if_addr_i = 32'h400;
    i_seen = 1'b0; i_data = 32'h0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_i);
      if (if_ack_o) begin
        i_seen = 1'b1;
        i_data = if_data_o;
        break;
      end
      @(posedge clk_i); #1;
      if (bus_req_o) if_req_i = 1'b0;
    end
    check("if_drop_ack", i_seen, 1'b1);
    check("if_drop_data", i_data, 32'h00000013);
    @(posedge clk_i); #1;

    // Both sides pending out of reset, then continuous traffic.
    lat = 1; rd_word = 32'hCAFE0001;
    rst_i = 1'b1;
    if_req_i = 1'b1; if_addr_i = 32'h1000;
    mem_op_i = 4'd3; mem_addr_i = 32'h100;
    #1;
    check("rst_stall_mem_comb", stallreq_mem_o, 1'b1);
    check("rst_stall_if_comb", stallreq_if_o, 1'b1);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    prev_req = 1'b0;
    for (int n = 0; n < 60 && order.size() < 4; n++) begin
      @(negedge clk_i);
      if (bus_req_o && !prev_req) order.push_back(bus_addr_o < 32'h1000);
      prev_req = bus_req_o;
      d_done = mem_ack_o;
      i_done = if_ack_o;
      @(posedge clk_i); #1;
      if (d_done) mem_addr_i = mem_addr_i ^ 32'h4;
      if (i_done) if_addr_i = if_addr_i + 32'h4;
    end
    check("rr_grants_seen", order.size(), 4);
    while (order.size() < 4) order.push_back(1'b0);
    check("rr_order", {order[0], order[1], order[2], order[3]}, 4'b1010);
    for (int n = 0; n < 20 && bus_req_o; n++) begin
      @(posedge clk_i); #1;
    end
    if_req_i = 1'b0; mem_op_i = 4'd0;
    repeat (4) begin
      @(posedge clk_i); #1;
    end

    // Reset while a D-side load is on the bus, then a stray late ack.
    lat = 10;
    mem_op_i = 4'd3; mem_addr_i = 32'h500;
    i_seen = 1'b0;
    for (int n = 0; n < 10 && !i_seen; n++) begin
      @(negedge clk_i);
      i_seen = bus_req_o;
    end
    check("mid_rst_busy", i_seen, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    check("mid_rst_bus_req", bus_req_o, 1'b0);
    check("mid_rst_mem_ack", mem_ack_o, 1'b0);
    check("mid_rst_if_ack", if_ack_o, 1'b0);
    check("mid_rst_mem_rdata", mem_rdata_o, 32'h0);
    check("mid_rst_if_data", if_data_o, 32'h0);
    mem_op_i = 4'd0;
    stray_ack = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    stray_ack = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      check("late_ack_mem_ack", mem_ack_o, 1'b0);
      check("late_ack_if_ack", if_ack_o, 1'b0);
      check("late_ack_bus_req", bus_req_o, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
